// File: rtl/quiz_pkg.sv
// Shared types and sizing for the quiz buzzer arbiter.
package quiz_pkg;

    localparam int unsigned NPLAYER         = 4;
    localparam int unsigned ANSWER_SECS_DEF = 5;
    localparam int unsigned PTR_W           = 2;
    localparam int unsigned TIME_W          = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ANSWER = 2'd2,
        POST   = 2'd3
    } state_t;

    // Index of the set bit in a one-hot player vector (0 when empty).
    function automatic logic [PTR_W-1:0] onehot_idx(input logic [NPLAYER-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(NPLAYER); i++) begin
            if (oh[i]) idx = PTR_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Four-way round-robin picker: first requester at or after ptr, wrapping.
module rr_pick4
    import quiz_pkg::*;
(
    input  logic [3:0]       req,
    input  logic [PTR_W-1:0] ptr,
    output logic [3:0]       gnt_c
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt_c = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + PTR_W'(i);
            if (!found && req[idx]) begin
                gnt_c[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/buzzer_arbiter.sv
// Quiz buzzer arbiter: grants one player an answer window per buzz, tracks
// per-round lockouts and counts the window down on 1 Hz ticks.
module buzzer_arbiter
    import quiz_pkg::*;
#(
    parameter int unsigned ANSWER_SECS = quiz_pkg::ANSWER_SECS_DEF,
    parameter int unsigned NPLAYER     = quiz_pkg::NPLAYER
) (
    input  logic              Clk100M,
    input  logic              nRst,
    input  logic              tick1Hz,
    input  logic              roundStart,
    input  logic [3:0]        buzz,
    input  logic              judgeOk,
    input  logic              judgeBad,
    output logic [3:0]        grant,
    output logic              answerSig,
    output logic              stopCount,
    output logic              postSig,
    output logic [3:0]        lockout,
    output logic [TIME_W-1:0] timeLeft
);

    localparam logic [3:0] ALL_LOCKED = 4'((1 << NPLAYER) - 1);

    state_t           state;
    logic [PTR_W-1:0] rr_ptr;
    logic [3:0]       pick_c;

    rr_pick4 u_pick (
        .req   (buzz & ~lockout),
        .ptr   (rr_ptr),
        .gnt_c (pick_c)
    );

    // Round control; every output is a register updated here.
    always_ff @(posedge Clk100M or negedge nRst) begin
        if (!nRst) begin
            state     <= IDLE;
            grant     <= '0;
            lockout   <= '0;
            timeLeft  <= '0;
            answerSig <= 1'b0;
            stopCount <= 1'b0;
            postSig   <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            answerSig <= 1'b0;
            stopCount <= 1'b0;
            postSig   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (roundStart) begin
                        lockout <= '0;
                        state   <= ARMED;
                    end
                end
                ARMED: begin
                    if (roundStart) begin
                        lockout <= '0;
                    end else if (|pick_c) begin
                        grant     <= pick_c;
                        answerSig <= 1'b1;
                        timeLeft  <= TIME_W'(ANSWER_SECS);
                        rr_ptr    <= onehot_idx(pick_c) + PTR_W'(1);
                        state     <= ANSWER;
                    end
                end
                ANSWER: begin
                    // Priority: abort, then correct answer, then wrong/timeout.
                    if (roundStart) begin
                        stopCount <= 1'b1;
                        lockout   <= '0;
                        grant     <= '0;
                        timeLeft  <= '0;
                        state     <= ARMED;
                    end else if (judgeOk) begin
                        stopCount <= 1'b1;
                        postSig   <= 1'b1;
                        grant     <= '0;
                        timeLeft  <= '0;
                        state     <= POST;
                    end else if (judgeBad || (tick1Hz && timeLeft == TIME_W'(1))) begin
                        stopCount <= 1'b1;
                        lockout   <= lockout | grant;
                        grant     <= '0;
                        timeLeft  <= '0;
                        if ((lockout | grant) == ALL_LOCKED) begin
                            postSig <= 1'b1;
                            state   <= POST;
                        end else begin
                            state   <= ARMED;
                        end
                    end else if (tick1Hz && timeLeft != '0) begin
                        timeLeft <= timeLeft - TIME_W'(1);
                    end
                end
                POST: begin
                    if (roundStart) begin
                        lockout <= '0;
                        state   <= ARMED;
                    end else begin
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
